reaction_game_core: RTL

//  Parametrised multi-round reaction-timer core: random delay, green LED, time the hit, store per-round score.

---
 rtl/reaction_game_core.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/reaction_game_core.sv
// reaction_game_core: multi-round reaction-timer game core.
//   Waits a pseudo-random delay, lights the green LED, times the player's hit
//   in ticks and stores one score per round. Detects false starts (hits before
//   green), scores missed rounds as MISS, and tracks the best score and the
//   per-game average.
// Ports:
//   Clock, CLRN                    system clock, async active-low reset
//   buttonStart/Hit/Reset          raw debounced levels, synchronised here
//   GreenLed                       high while in GO
//   RedLed                         high in FOUL and in DONE
//   State                          IDLE=0 ARM=1 GO=2 SCORE=3 FOUL=4 DONE=5
//   RoundIdx                       round in progress / last stored
//   LastScore, BestScore           latest score, minimum score this game
//   AvgScore                       game average, non-zero only in DONE
//   ScoreValid                     one-cycle pulse when a score is stored
module reaction_game_core #(
   parameter int unsigned DIV        = 50000,
   parameter int unsigned ROUNDS     = 4,
   parameter int unsigned SCORE_W    = 13,
   parameter int unsigned MIN_DELAY  = 1000,
   parameter int unsigned DELAY_MASK = 2047
) (
   input  logic                      Clock,
   input  logic                      CLRN,
   input  logic                      buttonStart,
   input  logic                      buttonHit,
   input  logic                      buttonReset,
   output logic                      GreenLed,
   output logic                      RedLed,
   output logic [2:0]                State,
   output logic [$clog2(ROUNDS)-1:0] RoundIdx,
   output logic [SCORE_W-1:0]        LastScore,
   output logic [SCORE_W-1:0]        BestScore,
   output logic [SCORE_W-1:0]        AvgScore,
   output logic                      ScoreValid
);

   localparam int unsigned IDX_W = $clog2(ROUNDS);
   localparam int unsigned PRE_W = $clog2(DIV);
   localparam int unsigned SUM_W = SCORE_W + IDX_W;
   localparam int unsigned DLY_W = 32;
   localparam logic [SCORE_W-1:0] MISS    = '1;
   localparam logic [SCORE_W-1:0] MISS_M1 = MISS - SCORE_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      GO    = 3'd2,
      SCORE = 3'd3,
      FOUL  = 3'd4,
      DONE  = 3'd5
   } stateT;

   stateT              state, stateNext;
   logic [2:0]         startSync, hitSync, rstSync;
   logic               startEdge, hitEdge, rstEdge;
   logic [PRE_W-1:0]   preCnt;
   logic               tick;
   logic [15:0]        lfsr;
   logic               lfsrFb;
   logic [DLY_W-1:0]   delayCnt, delayNext, delayLoad;
   logic [SCORE_W-1:0] scoreCnt, scoreNext;
   logic [IDX_W-1:0]   idxNext;
   logic [SCORE_W-1:0] lastNext, bestNext, avgNext;
   logic [SCORE_W-1:0] mem [ROUNDS];
   logic               memWe, memClr;
   logic [SUM_W-1:0]   scoreTotal;

   // Button synchronisers and rising-edge detect; untouched by soft reset so a
   // held button never produces a second edge.
   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN) begin
         startSync <= '0;
         hitSync   <= '0;
         rstSync   <= '0;
      end else begin
         startSync <= {startSync[1:0], buttonStart};
         hitSync   <= {hitSync[1:0], buttonHit};
         rstSync   <= {rstSync[1:0], buttonReset};
      end
   end

   assign startEdge = startSync[1] & ~startSync[2];
   assign hitEdge   = hitSync[1] & ~hitSync[2];
   assign rstEdge   = rstSync[1] & ~rstSync[2];

   // Tick prescaler; soft reset realigns it like a hard reset.
   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN)                preCnt <= '0;
      else if (rstEdge || tick) preCnt <= '0;
      else                      preCnt <= preCnt + PRE_W'(1);
   end

   assign tick = (preCnt == PRE_W'(DIV - 1));

   // Free-running LFSR x^16+x^14+x^13+x^11; deliberately kept across soft reset.
   assign lfsrFb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsrFb};
   end

   assign delayLoad = DLY_W'(MIN_DELAY) + DLY_W'(lfsr & 16'(DELAY_MASK));

   // Game total with the score being stored substituted for its memory slot.
   always_comb begin
      scoreTotal = '0;
      for (int i = 0; i < ROUNDS; i++) begin
         scoreTotal = scoreTotal +
                      SUM_W'((IDX_W'(i) == RoundIdx) ? scoreCnt : mem[i]);
      end
   end

   // Next-state and datapath decisions.
   always_comb begin
      stateNext = state;
      delayNext = delayCnt;
      scoreNext = scoreCnt;
      idxNext   = RoundIdx;
      lastNext  = LastScore;
      bestNext  = BestScore;
      avgNext   = AvgScore;
      memWe     = 1'b0;
      memClr    = 1'b0;
      if (rstEdge) begin
         stateNext = IDLE;
         delayNext = '0;
         scoreNext = '0;
         idxNext   = '0;
         lastNext  = '0;
         bestNext  = '1;
         avgNext   = '0;
         memClr    = 1'b1;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (startEdge) begin
                  stateNext = ARM;
                  delayNext = delayLoad;
                  idxNext   = '0;
                  bestNext  = '1;
                  avgNext   = '0;
                  memClr    = 1'b1;
               end
            end
            ARM: begin
               // A hit landing exactly as green comes on counts as a zero score.
               if (delayCnt == '0) begin
                  scoreNext = '0;
                  stateNext = hitEdge ? SCORE : GO;
               end else if (hitEdge) begin
                  stateNext = FOUL;
               end else if (tick) begin
                  delayNext = delayCnt - DLY_W'(1);
               end
            end
            GO: begin
               // Saturation wins over a simultaneous hit.
               if (tick && (scoreCnt == MISS_M1)) begin
                  scoreNext = MISS;
                  stateNext = SCORE;
               end else if (hitEdge) begin
                  stateNext = SCORE;
               end else if (tick) begin
                  scoreNext = scoreCnt + SCORE_W'(1);
               end
            end
            FOUL: begin
               if (tick) begin
                  scoreNext = MISS;
                  stateNext = SCORE;
               end
            end
            SCORE: begin
               memWe    = 1'b1;
               lastNext = scoreCnt;
               bestNext = (scoreCnt < BestScore) ? scoreCnt : BestScore;
               if (RoundIdx == IDX_W'(ROUNDS - 1)) begin
                  stateNext = DONE;
                  avgNext   = SCORE_W'(scoreTotal >> IDX_W);
               end else begin
                  stateNext = ARM;
                  idxNext   = RoundIdx + IDX_W'(1);
                  delayNext = delayLoad;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // State and registered outputs; LEDs follow the next state so they line up with State.
   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN) begin
         state      <= IDLE;
         delayCnt   <= '0;
         scoreCnt   <= '0;
         RoundIdx   <= '0;
         LastScore  <= '0;
         BestScore  <= '1;
         AvgScore   <= '0;
         ScoreValid <= 1'b0;
         GreenLed   <= 1'b0;
         RedLed     <= 1'b0;
      end else begin
         state      <= stateNext;
         delayCnt   <= delayNext;
         scoreCnt   <= scoreNext;
         RoundIdx   <= idxNext;
         LastScore  <= lastNext;
         BestScore  <= bestNext;
         AvgScore   <= avgNext;
         ScoreValid <= memWe;
         GreenLed   <= (stateNext == GO);
         RedLed     <= (stateNext == FOUL) || (stateNext == DONE);
      end
   end

   // Per-round score memory.
   always_ff @(posedge Clock or negedge CLRN) begin
      if (!CLRN) begin
         for (int i = 0; i < ROUNDS; i++) mem[i] <= '0;
      end else if (memClr) begin
         for (int i = 0; i < ROUNDS; i++) mem[i] <= '0;
      end else if (memWe) begin
         mem[RoundIdx] <= scoreCnt;
      end
   end

   assign State = state;

endmodule
